ext_irq_ctrl: RTL and testbench
===============================

// Module: ext_irq_ctrl
// PURPOSE
//  External interrupt controller; the device-side end of the extIRQ/extIAck handshake.
//  Collects interrupt pulses from N peripheral sources and keeps per-source pending counts.
//  Arbitrates among unmasked sources and drives a level request into the core.
//  Holds the request until the core acknowledges, then retires one event.
//  Sits between peripherals and the processor top level; extIRQ feeds the core controller,
//  extIAck returns from it.
// PARAMETERS
//  N_SRC    4  number of interrupt sources (2..16)
//  CNT_W    3  pending-counter width per source; saturates at 2**CNT_W-1
//  GAP_CYC  2  idle cycles forced after each ack, before the next request (>=1)
// PORTS
//  clk         in   1                    system clock, all logic on posedge
//  reset       in   1                    synchronous, active-high
//  irq_pulse   in   N_SRC                one-cycle event per source; level high = one event per cycle
//  irq_mask    in   N_SRC                1 = source enabled for arbitration
//  ovf_clr     in   1                    clears all overflow flags
//  extIAck     in   1                    core acknowledge of the current request
//  extIRQ      out  1                    registered level request to the core
//  irq_id      out  $clog2(N_SRC)        id of the source being requested; stable while extIRQ=1
//  pending     out  N_SRC                per source: count != 0
//  overflow    out  N_SRC                sticky: an event was lost because its counter was saturated
// BEHAVIOUR
//  Reset: all counters=0, extIRQ=0, irq_id=0, overflow=0, FSM=IDLE; applies even mid-handshake.
//  FSM IDLE -> REQ: some source i has pending[i] & irq_mask[i].
//   - The lowest such i wins (fixed priority, 0 highest).
//   - irq_id<=i and extIRQ<=1 on the same edge: one cycle from the enabling condition to extIRQ.
//  FSM REQ:
//   - extIRQ=1 and irq_id frozen; mask changes and new pulses do not alter the request.
//   - extIAck=1 -> GAP: extIRQ<=0, count[irq_id] decremented, gap counter loaded.
//  FSM GAP:
//   - extIRQ=0; the next request is allowed only after GAP_CYC cycles.
//   - After GAP_CYC cycles -> IDLE, and arbitration is re-evaluated that cycle.
//  extIAck is ignored in IDLE and GAP (no decrement, no error).
//  Counter update per source per cycle:
//   - +1 on irq_pulse; -1 on ack of that id.
//   - pulse and ack on the same id in the same cycle: net 0.
//   - pulse at saturation without ack: count holds, overflow[i]<=1.
//   - pulse at saturation with ack: net 0, no overflow.
//  Counters run regardless of mask; masking only gates arbitration.
//  ovf_clr and a new overflow in the same cycle: the flag stays set (set wins).
//  pending is combinational from the counters.
//   - During REQ, pending[irq_id] stays 1 until the ack decrements the count to 0.
//  All outputs are registered except pending.
// STRUCTURE
//  Shared package irq_pkg:
//   - typedef enum logic [1:0] {IRQ_IDLE, IRQ_REQ, IRQ_GAP} irq_state_t
//   - localparam for the EStatus code of an external IRQ (4'b0001), so core and controller agree.
//  One sub-module: irq_pend_cnt.
//   - One saturating up/down counter with an overflow flag.
//   - Instantiated N_SRC times via generate.
//  Priority encoder, FSM and gap counter live in ext_irq_ctrl.
// TESTING
//  1 Reset, pulse src2 once, mask=4'b1111: extIRQ=1, irq_id=2 next cycle.
//    extIAck 1 cycle -> extIRQ=0, pending=0.
//  2 Pulse src3 and src1 together: id=1 served first.
//    After ack + 2 gap cycles: id=3 requested, so extIRQ low for exactly GAP_CYC cycles.
//  3 Pulse src0 8 times with no ack (CNT_W=3): count=7, overflow[0]=1.
//    ovf_clr clears the flag; 7 acks drain to pending[0]=0.
//  4 In REQ with id=1, pulse src0 and clear mask[1]: irq_id stays 1 until ack.
//    Then id=0 follows.
//  5 Same-cycle pulse and ack on the current id with count=1: count stays 1.
//    A new request for the same id follows the gap.
//  6 Assert reset while extIRQ=1 with counts nonzero: next cycle extIRQ=0, pending=0, overflow=0.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the external interrupt handshake between the
// interrupt controller and the core controller.
package irq_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_REQ  = 2'd1,
    IRQ_GAP  = 2'd2
  } irq_state_t;

  // EStatus code the core records when it takes an external interrupt.
  localparam logic [3:0] ESTATUS_EXT_IRQ = 4'b0001;

endpackage : irq_pkg

// File: rtl/irq_pend_cnt.sv
// Per-source saturating pending-event counter with a sticky overflow flag.
// A simultaneous increment and decrement cancel, even at saturation.
module irq_pend_cnt #(
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  input  logic dec_i,
  input  logic ovf_clr_i,
  output logic nonzero_o,
  output logic overflow_o
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  // Next count and overflow; a set of the flag wins over a clear.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q & ~ovf_clr_i;
    if (inc_i && !dec_i) begin
      if (cnt_q == CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else if (dec_i && !inc_i && (cnt_q != CNT_ZERO)) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= CNT_ZERO;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign nonzero_o  = (cnt_q != CNT_ZERO);
  assign overflow_o = ovf_q;

endmodule : irq_pend_cnt

// File: rtl/ext_irq_ctrl.sv
// External interrupt controller: counts per-source events, picks the lowest
// unmasked pending source and holds extIRQ until the core acknowledges.
module ext_irq_ctrl
  import irq_pkg::*;
#(
  parameter int N_SRC   = 4,
  parameter int CNT_W   = 3,
  parameter int GAP_CYC = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_SRC-1:0]         irq_pulse,
  input  logic [N_SRC-1:0]         irq_mask,
  input  logic                     ovf_clr,
  input  logic                     extIAck,
  output logic                     extIRQ,
  output logic [$clog2(N_SRC)-1:0] irq_id,
  output logic [N_SRC-1:0]         pending,
  output logic [N_SRC-1:0]         overflow
);

  localparam int ID_W  = $clog2(N_SRC);
  localparam int GAP_W = $clog2(GAP_CYC + 1);

  irq_state_t       state_q, state_d;
  logic             irq_q, irq_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic [N_SRC-1:0] dec_s;
  logic [N_SRC-1:0] req_s;
  logic [ID_W-1:0]  win_s;
  logic             any_req_s;

  for (genvar g = 0; g < N_SRC; g++) begin : g_cnt
    irq_pend_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .inc_i     (irq_pulse[g]),
      .dec_i     (dec_s[g]),
      .ovf_clr_i (ovf_clr),
      .nonzero_o (pending[g]),
      .overflow_o(overflow[g])
    );
  end

  // Only an ack of a live request retires an event, and only for the granted id.
  always_comb begin
    dec_s = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if ((state_q == IRQ_REQ) && extIAck && (id_q == ID_W'(i))) begin
        dec_s[i] = 1'b1;
      end else begin
        dec_s[i] = 1'b0;
      end
    end
  end

  assign req_s     = pending & irq_mask;
  assign any_req_s = |req_s;

  // Fixed priority: scanning downwards leaves the lowest requesting index.
  always_comb begin
    win_s = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req_s[i]) begin
        win_s = ID_W'(i);
      end else begin
        win_s = win_s;
      end
    end
  end

  // Handshake FSM; the last gap cycle arbitrates directly so the line is low
  // for exactly GAP_CYC cycles between back-to-back requests.
  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    id_d    = id_q;
    gap_d   = gap_q;
    case (state_q)
      IRQ_IDLE: begin
        if (any_req_s) begin
          state_d = IRQ_REQ;
          irq_d   = 1'b1;
          id_d    = win_s;
        end else begin
          irq_d   = 1'b0;
        end
      end
      IRQ_REQ: begin
        if (extIAck) begin
          state_d = IRQ_GAP;
          irq_d   = 1'b0;
          gap_d   = GAP_W'(GAP_CYC);
        end else begin
          irq_d   = 1'b1;
        end
      end
      IRQ_GAP: begin
        if (gap_q <= GAP_W'(1)) begin
          gap_d = '0;
          if (any_req_s) begin
            state_d = IRQ_REQ;
            irq_d   = 1'b1;
            id_d    = win_s;
          end else begin
            state_d = IRQ_IDLE;
          end
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: begin
        state_d = IRQ_IDLE;
        irq_d   = 1'b0;
        gap_d   = '0;
      end
    endcase
  end

  // FSM and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IRQ_IDLE;
      irq_q   <= 1'b0;
      id_q    <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_d;
      id_q    <= id_d;
      gap_q   <= gap_d;
    end
  end

  assign extIRQ = irq_q;
  assign irq_id = id_q;

endmodule : ext_irq_ctrl

// File: tb/tb_ext_irq_ctrl.sv
// Directed and randomized checks of ext_irq_ctrl against a cycle-level
// reference model built from per-source event counts.
module tb_ext_irq_ctrl;

  localparam int N   = 4;
  localparam int MAXC = 7;
  localparam int GAP = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   irq_pulse;
  logic [3:0]   irq_mask;
  logic         ovf_clr;
  logic         extIAck;
  logic         extIRQ;
  logic [1:0]   irq_id;
  logic [3:0]   pending;
  logic [3:0]   overflow;

  int tests_run = 0;
  int tests_failed = 0;

  // reference model state
  int   m_cnt [N];
  logic [3:0] m_ovf;
  logic m_irq;
  int   m_id;
  int   m_gap;

  ext_irq_ctrl #(.N_SRC(4), .CNT_W(3), .GAP_CYC(2)) dut (
    .clk(clk), .reset(reset), .irq_pulse(irq_pulse), .irq_mask(irq_mask),
    .ovf_clr(ovf_clr), .extIAck(extIAck), .extIRQ(extIRQ), .irq_id(irq_id),
    .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] m_pending();
    logic [3:0] p;
    for (int i = 0; i < N; i++) p[i] = (m_cnt[i] != 0);
    return p;
  endfunction

  // Advance the model by one clock given the inputs sampled at that edge.
  task automatic model_edge(input logic rst, input logic [3:0] pl, input logic [3:0] mk,
                            input logic clr, input logic ack);
    int  win;
    bit  fire;
    logic [3:0] set;
    if (rst) begin
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_ovf = 4'b0000; m_irq = 1'b0; m_id = 0; m_gap = 0;
      return;
    end
    win = -1;
    for (int i = N - 1; i >= 0; i--) if (m_cnt[i] != 0 && mk[i]) win = i;
    fire = m_irq && ack;
    set = 4'b0000;
    for (int i = 0; i < N; i++) begin
      int delta;
      delta = (pl[i] ? 1 : 0) - ((fire && m_id == i) ? 1 : 0);
      if (delta > 0 && m_cnt[i] == MAXC) set[i] = 1'b1;
      else m_cnt[i] = m_cnt[i] + delta;
    end
    m_ovf = (clr ? 4'b0000 : m_ovf) | set;
    if (m_irq) begin
      if (ack) begin m_irq = 1'b0; m_gap = GAP; end
    end else if (m_gap > 1) begin
      m_gap = m_gap - 1;
    end else begin
      m_gap = 0;
      if (win >= 0) begin m_irq = 1'b1; m_id = win; end
    end
  endtask

  task automatic step(input logic rst, input logic [3:0] pl, input logic [3:0] mk,
                      input logic clr, input logic ack);
    reset = rst; irq_pulse = pl; irq_mask = mk; ovf_clr = clr; extIAck = ack;
    @(posedge clk);
    model_edge(rst, pl, mk, clr, ack);
    #1;
    chk("extIRQ", {31'd0, extIRQ}, {31'd0, m_irq});
    if (m_irq) chk("irq_id", {30'd0, irq_id}, m_id);
    chk("pending", {28'd0, pending}, {28'd0, m_pending()});
    chk("overflow", {28'd0, overflow}, {28'd0, m_ovf});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 4'b0000, 4'b1111, 1'b0, 1'b0);
  endtask

  initial begin
    int acks;
    m_ovf = 4'b0000; m_irq = 1'b0; m_id = 0; m_gap = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;

    // 1: reset, single event on src2
    step(1'b1, 4'b0000, 4'b1111, 1'b0, 1'b0);
    step(1'b1, 4'b0000, 4'b1111, 1'b0, 1'b0);
    chk("t1_rst_irq", {31'd0, extIRQ}, 32'd0);
    chk("t1_rst_id", {30'd0, irq_id}, 32'd0);
    chk("t1_rst_ovf", {28'd0, overflow}, 32'd0);
    step(1'b0, 4'b0100, 4'b1111, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 4'b1111, 1'b0, 1'b0);
    chk("t1_irq", {31'd0, extIRQ}, 32'd1);
    chk("t1_id", {30'd0, irq_id}, 32'd2);
    step(1'b0, 4'b0000, 4'b1111, 1'b0, 1'b1);
    chk("t1_ack_irq", {31'd0, extIRQ}, 32'd0);
    chk("t1_ack_pend", {28'd0, pending}, 32'd0);
    idle(3);

    // 2: simultaneous src3 and src1, exact gap length
    step(1'b0, 4'b1010, 4'b1111, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 4'b1111, 1'b0, 1'b0);
    chk("t2_id1", {30'd0, irq_id}, 32'd1);
    step(1'b0, 4'b0000, 4'b1111, 1'b0, 1'b1);
    chk("t2_gap0", {31'd0, extIRQ}, 32'd0);
    step(1'b0, 4'b0000, 4'b1111, 1'b0, 1'b0);
    chk("t2_gap1", {31'd0, extIRQ}, 32'd0);
    step(1'b0, 4'b0000, 4'b1111, 1'b0, 1'b0);
    chk("t2_irq3", {31'd0, extIRQ}, 32'd1);
    chk("t2_id3", {30'd0, irq_id}, 32'd3);
    step(1'b0, 4'b0000, 4'b1111, 1'b0, 1'b1);
    idle(3);

    // 3: saturate src0, clear overflow, drain
    for (int k = 0; k < 8; k++) step(1'b0, 4'b0001, 4'b1111, 1'b0, 1'b0);
    chk("t3_ovf", {28'd0, overflow}, 32'd1);
    chk("t3_cnt", m_cnt[0], 32'd7);
    step(1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0);
    chk("t3_ovf_clr", {28'd0, overflow}, 32'd0);
    acks = 0;
    for (int k = 0; k < 60 && acks < 7; k++) begin
      if (m_irq) acks++;
      step(1'b0, 4'b0000, 4'b1111, 1'b0, m_irq);
    end
    chk("t3_acks", acks, 32'd7);
    chk("t3_drained", {31'd0, pending[0]}, 32'd0);
    idle(3);

    // 4: request frozen against mask change and higher-priority pulse
    step(1'b0, 4'b0010, 4'b1111, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 4'b1111, 1'b0, 1'b0);
    step(1'b0, 4'b0001, 4'b1101, 1'b0, 1'b0);
    chk("t4_frozen_a", {30'd0, irq_id}, 32'd1);
    step(1'b0, 4'b0000, 4'b1101, 1'b0, 1'b0);
    chk("t4_frozen_b", {30'd0, irq_id}, 32'd1);
    chk("t4_held", {31'd0, extIRQ}, 32'd1);
    step(1'b0, 4'b0000, 4'b1111, 1'b0, 1'b1);
    idle(2);
    chk("t4_next_id0", {30'd0, irq_id}, 32'd0);
    chk("t4_next_irq", {31'd0, extIRQ}, 32'd1);
    step(1'b0, 4'b0000, 4'b1111, 1'b0, 1'b1);
    idle(3);

    // 5: pulse and ack on the served id in one cycle
    step(1'b0, 4'b0100, 4'b1111, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 4'b1111, 1'b0, 1'b0);
    step(1'b0, 4'b0100, 4'b1111, 1'b0, 1'b1);
    chk("t5_pend2", {31'd0, pending[2]}, 32'd1);
    chk("t5_cnt2", m_cnt[2], 32'd1);
    idle(2);
    chk("t5_rereq", {31'd0, extIRQ}, 32'd1);
    chk("t5_rereq_id", {30'd0, irq_id}, 32'd2);

    // 6: reset mid-handshake with overflow and counts set
    for (int k = 0; k < 9; k++) step(1'b0, 4'b1000, 4'b1111, 1'b0, 1'b0);
    chk("t6_pre_ovf", {31'd0, overflow[3]}, 32'd1);
    step(1'b1, 4'b0000, 4'b1111, 1'b0, 1'b0);
    chk("t6_irq", {31'd0, extIRQ}, 32'd0);
    chk("t6_pend", {28'd0, pending}, 32'd0);
    chk("t6_ovf", {28'd0, overflow}, 32'd0);

    // randomized traffic against the model
    for (int k = 0; k < 1500; k++) begin
      logic [3:0] pl;
      logic [3:0] mk;
      pl = 4'($urandom) & 4'($urandom) & 4'($urandom);
      mk = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b1111;
      if ($urandom_range(0, 3) == 0) mk = 4'b1110;
      step(($urandom_range(0, 299) == 0), pl, mk,
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_ext_irq_ctrl
